// File: rtl/display_pkg.sv
// Shared types and sizing helpers for the multiplexed display scanner.
package display_pkg;

   localparam int DIGIT_W = 3;

   typedef enum logic [1:0] {
      OFF   = 2'd0,
      GUARD = 2'd1,
      SHOW  = 2'd2
   } state_t;

   // Counter must hold the larger of the two interval reloads; never narrower than 1 bit.
   function automatic int cnt_width(input int scan_div, input int guard_cycles);
      int m;
      m = (scan_div > guard_cycles) ? scan_div : guard_cycles;
      return (m > 1) ? $clog2(m) : 1;
   endfunction

endpackage

// File: rtl/display_scan_ctrl_if.sv
// Update handshake and display-side signals of the scan controller.
interface display_scan_ctrl_if #(
   parameter int NUM_DIGITS = 4
);
   import display_pkg::*;

   logic                          enable;
   logic [DIGIT_W*NUM_DIGITS-1:0] digits_in;
   logic [NUM_DIGITS-1:0]         mask_in;
   logic                          upd_req;
   logic                          upd_ack;
   logic [DIGIT_W-1:0]            sel;
   logic [NUM_DIGITS-1:0]         dig_n;
   logic                          frame_tick;

   modport master (
      output enable, digits_in, mask_in, upd_req,
      input  upd_ack, sel, dig_n, frame_tick
   );

   modport slave (
      input  enable, digits_in, mask_in, upd_req,
      output upd_ack, sel, dig_n, frame_tick
   );

endinterface

// File: rtl/display_scan_ctrl_timer.sv
// Loadable down counter with a zero flag; holds at zero when not reloaded.
module scan_timer #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic         dec,
   input  logic [W-1:0] load_val,
   output logic         zero
);

   logic [W-1:0] cnt_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_reg <= '0;
      end else if (load) begin
         cnt_reg <= load_val;
      end else if (dec && (cnt_reg != '0)) begin
         cnt_reg <= cnt_reg - 1'b1;
      end
   end

   assign zero = (cnt_reg == '0);

endmodule

// File: rtl/display_scan_ctrl.sv
// Scans shadowed digit values onto a shared decoder with an all-dark guard before each slot;
// the shadow copy only changes in OFF or at the frame wrap so frames never mix data.
module display_scan_ctrl
   import display_pkg::*;
#(
   parameter int NUM_DIGITS   = 4,
   parameter int SCAN_DIV     = 50000,
   parameter int GUARD_CYCLES = 500
) (
   input  logic                clk,
   input  logic                rst_n,
   display_scan_ctrl_if.slave  bus
);

   localparam int CNT_W = cnt_width(SCAN_DIV, GUARD_CYCLES);
   localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

   state_t                        state_reg, state_next;
   logic [IDX_W-1:0]              idx_reg, idx_next, idx_inc;
   logic [DIGIT_W-1:0]            sel_reg, sel_next;
   logic [NUM_DIGITS-1:0]         dig_n_reg, dig_n_next;
   logic                          upd_ack_reg, upd_ack_next;
   logic                          frame_tick_reg, frame_tick_next;
   logic [DIGIT_W*NUM_DIGITS-1:0] shadow_dig_reg;
   logic [NUM_DIGITS-1:0]         shadow_mask_reg;

   logic [DIGIT_W-1:0]            shadow_arr [NUM_DIGITS];
   logic [NUM_DIGITS-1:0]         slot_n;
   logic                          idx_last, wrap_edge, capture;
   logic                          tmr_load, tmr_dec, tmr_zero;
   logic [CNT_W-1:0]              tmr_val;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
         assign shadow_arr[gi] = shadow_dig_reg[gi*DIGIT_W +: DIGIT_W];
         assign slot_n[gi]     = ~((idx_reg == IDX_W'(gi)) & shadow_mask_reg[gi]);
      end
   endgenerate

   assign idx_inc   = idx_reg + 1'b1;
   assign idx_last  = (idx_reg == IDX_W'(NUM_DIGITS - 1));
   // Disable takes priority over the wrap, so an edge that drops to OFF never captures there.
   assign wrap_edge = (state_reg == SHOW) && bus.enable && tmr_zero && idx_last;
   assign capture   = bus.upd_req && !upd_ack_reg && ((state_reg == OFF) || wrap_edge);

   scan_timer #(.W(CNT_W)) u_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (tmr_load),
      .dec      (tmr_dec),
      .load_val (tmr_val),
      .zero     (tmr_zero)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= OFF;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         OFF:     if (bus.enable) state_next = GUARD;
         GUARD:   if (!bus.enable) state_next = OFF;
                  else if (tmr_zero) state_next = SHOW;
         SHOW:    if (!bus.enable) state_next = OFF;
                  else if (tmr_zero) state_next = GUARD;
         default: state_next = OFF;
      endcase
   end

   always_comb begin
      idx_next        = idx_reg;
      sel_next        = sel_reg;
      dig_n_next      = '1;
      frame_tick_next = 1'b0;
      upd_ack_next    = capture;
      tmr_load        = 1'b0;
      tmr_dec         = 1'b0;
      tmr_val         = '0;
      case (state_reg)
         OFF: begin
            idx_next = '0;
            if (bus.enable) begin
               tmr_load = 1'b1;
               tmr_val  = CNT_W'(GUARD_CYCLES - 1);
               sel_next = capture ? bus.digits_in[DIGIT_W-1:0] : shadow_arr[0];
            end
         end
         GUARD: begin
            if (!bus.enable) begin
               idx_next = '0;
               tmr_load = 1'b1;
            end else if (tmr_zero) begin
               tmr_load   = 1'b1;
               tmr_val    = CNT_W'(SCAN_DIV - 1);
               dig_n_next = slot_n;
            end else begin
               tmr_dec = 1'b1;
            end
         end
         SHOW: begin
            if (!bus.enable) begin
               idx_next = '0;
               tmr_load = 1'b1;
            end else if (tmr_zero) begin
               tmr_load = 1'b1;
               tmr_val  = CNT_W'(GUARD_CYCLES - 1);
               if (!idx_last) begin
                  idx_next = idx_inc;
                  sel_next = shadow_arr[idx_inc];
               end else begin
                  // New frame starts with freshly captured data when an update lands here.
                  idx_next        = '0;
                  sel_next        = capture ? bus.digits_in[DIGIT_W-1:0] : shadow_arr[0];
                  frame_tick_next = 1'b1;
               end
            end else begin
               tmr_dec    = 1'b1;
               dig_n_next = dig_n_reg;
            end
         end
         default: idx_next = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_reg         <= '0;
         sel_reg         <= '0;
         dig_n_reg       <= '1;
         upd_ack_reg     <= 1'b0;
         frame_tick_reg  <= 1'b0;
         shadow_dig_reg  <= '0;
         shadow_mask_reg <= '0;
      end else begin
         idx_reg        <= idx_next;
         sel_reg        <= sel_next;
         dig_n_reg      <= dig_n_next;
         upd_ack_reg    <= upd_ack_next;
         frame_tick_reg <= frame_tick_next;
         if (capture) begin
            shadow_dig_reg  <= bus.digits_in;
            shadow_mask_reg <= bus.mask_in;
         end
      end
   end

   assign bus.sel        = sel_reg;
   assign bus.dig_n      = dig_n_reg;
   assign bus.upd_ack    = upd_ack_reg;
   assign bus.frame_tick = frame_tick_reg;

endmodule
